bsg_permute_box_ctrl: RTL
=========================

// Module: bsg_permute_box_ctrl
// PURPOSE
//  Configuration controller for a bsg_permute_box. Software/host writes a shadow permutation one entry at a
//  time, then requests a commit; the block optionally checks the shadow is a bijection and swaps it into the
//  active select vector only at a packet boundary of the data stream that flows through the permute box.
//  It drives the box's select input; the box is instantiated next to it in the datapath.
// PARAMETERS
//  els_p    8                  number of permuted elements (>=2)
//  lg_els_lp  $clog2(els_p)    derived local parameter: select field width per element
// PORTS
//  clk_i           in   1                  clock
//  reset_i         in   1                  asynchronous reset, active-high
//  cfg_v_i         in   1                  shadow write valid
//  cfg_idx_i       in   lg_els_lp          output element index being written
//  cfg_sel_i       in   lg_els_lp          input element that output cfg_idx_i selects
//  cfg_ready_o     out  1                  shadow write accepted (high only in IDLE)
//  commit_v_i      in   1                  commit request
//  commit_ready_o  out  1                  commit accepted (high only in IDLE)
//  commit_done_o   out  1                  1-cycle pulse: swap performed
//  commit_err_o    out  1                  1-cycle pulse: commit rejected (not a bijection)
//  data_v_i        in   1                  stream beat valid (observed at permute box input)
//  data_ready_i    in   1                  stream beat ready
//  data_last_i     in   1                  last beat of packet
//  busy_o          out  1                  state != IDLE
//  select_o        out  els_p*lg_els_lp    active select vector; field i = source for output i
// BEHAVIOUR
//  - Reset (async, active-high): FSM=IDLE; shadow and select_o = identity (field i = i); in_flight_r=0;
//    commit_done_o=commit_err_o=0; busy_o=0. Reset mid-commit abandons it; no pulse is emitted.
//  - Handshakes: cfg write when cfg_v_i&cfg_ready_o; commit when commit_v_i&commit_ready_o. Writes
//    outside IDLE are stalled, never dropped. Same-cycle write+commit: write lands in shadow first, commit
//    uses the updated shadow.
//  - in_flight_r: set on beat (data_v_i&data_ready_i&~data_last_i); cleared on beat with data_last_i.
//  - FSM: IDLE -commit-> CHECK (or WAIT_SWAP if check compiled out).
//    CHECK: counter k=0..els_p-1, one shadow field per cycle; seen-bitmask bit sel[k] set; if already set
//    -> ERR. After k=els_p-1 without duplicate -> WAIT_SWAP. ERR: commit_err_o=1 for one cycle, active
//    select unchanged, shadow kept, -> IDLE.
//    WAIT_SWAP: swap when (~in_flight_r & ~(data_v_i&data_ready_i)) | (data_v_i&data_ready_i&data_last_i);
//    in that cycle commit_done_o=1, select_o<=shadow at the clock edge, -> IDLE. Otherwise hold.
//  - Latency (check on, idle stream): commit at cycle T; CHECK T+1..T+els_p; done pulse T+els_p+1;
//    new select_o visible T+els_p+2. A beat in the swap cycle still uses the old select.
//  - Counter k is lg_els_lp+1 bits; no wrap within CHECK. cfg_idx_i >= els_p (non-power-of-2) is ignored.
// CONFIGURATION
//  BSG_PERMUTE_BOX_CTRL_CHECK_EN defined: CHECK/ERR states present as above.
//  Undefined: no checker; commit goes IDLE->WAIT_SWAP at T+1; commit_err_o tied 0; any shadow (including
//  duplicates, i.e. broadcast) is committed.
// STRUCTURE
//  - Package bsg_permute_box_ctrl_pkg: state enum {IDLE, CHECK, ERR, WAIT_SWAP}; identity-vector function.
//  - Sub-module bsg_permute_box_ctrl_checker: serial bijection checker (counter + seen mask, start/done/err),
//    instantiated only under BSG_PERMUTE_BOX_CTRL_CHECK_EN.
// TESTING (els_p=8)
//  1 Reset -> select_o = identity (field i=i), busy_o=0, no pulses; mid-CHECK reset -> IDLE, no done/err.
//  2 Write reversal (idx i -> sel 7-i), commit at T, stream idle -> done at T+9, select_o reversed at T+10.
//  3 Write idx0=3 and idx1=3 (duplicate), commit -> err pulse, select_o unchanged, next commit after fix ok.
//  4 Packet of 4 beats in flight at commit -> swap only on last-beat cycle; all 4 beats use old mapping.
//  5 Same-cycle cfg write idx2=5 + commit -> committed map includes idx2=5; cfg_ready_o=0 during CHECK.
//  6 Macro undefined: duplicate map commits, done at T+1 (idle stream), commit_err_o never asserts.

Source files
------------

// File: rtl/bsg_permute_box_ctrl_pkg.sv
// Shared types and helpers for the permute-box configuration controller.
// Optional feature macro: BSG_PERMUTE_BOX_CTRL_CHECK_EN (serial bijection checker).
package bsg_permute_box_ctrl_pkg;

    // Controller states; CHECK and ERR are only reachable when the checker is built in.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CHECK     = 2'd1,
        ST_ERR       = 2'd2,
        ST_WAIT_SWAP = 2'd3
    } state_e;

    // Upper bound on a packed select vector handled by the helper below.
    localparam int unsigned max_vec_w_lp = 1024;

    // Identity mapping: field i = i, fields packed LSB first, each lg bits wide.
    // Built by shifting so no variable bit index is needed; callers truncate.
    function automatic logic [max_vec_w_lp-1:0] identity_vec(input int unsigned els,
                                                             input int unsigned lg);
        logic [max_vec_w_lp-1:0] v;
        v = '0;
        for (int unsigned i = els; i > 0; i--) begin
            v = (v << lg) | max_vec_w_lp'(i - 32'd1);
        end
        return v;
    endfunction

endpackage

// File: rtl/bsg_permute_box_ctrl_if.sv
// Handshake/stream bundle between the host, the stream monitor point and the controller.
// slave = controller side, master = host/testbench side.
interface bsg_permute_box_ctrl_if #(parameter int els_p = 8);

    localparam int lg_els_lp = $clog2(els_p);

    logic                         cfg_v_i;
    logic [lg_els_lp-1:0]         cfg_idx_i;
    logic [lg_els_lp-1:0]         cfg_sel_i;
    logic                         cfg_ready_o;
    logic                         commit_v_i;
    logic                         commit_ready_o;
    logic                         commit_done_o;
    logic                         commit_err_o;
    logic                         data_v_i;
    logic                         data_ready_i;
    logic                         data_last_i;
    logic                         busy_o;
    logic [els_p*lg_els_lp-1:0]   select_o;

    modport slave (
        input  cfg_v_i, cfg_idx_i, cfg_sel_i, commit_v_i,
        input  data_v_i, data_ready_i, data_last_i,
        output cfg_ready_o, commit_ready_o, commit_done_o, commit_err_o,
        output busy_o, select_o
    );

    modport master (
        output cfg_v_i, cfg_idx_i, cfg_sel_i, commit_v_i,
        output data_v_i, data_ready_i, data_last_i,
        input  cfg_ready_o, commit_ready_o, commit_done_o, commit_err_o,
        input  busy_o, select_o
    );

endinterface

// File: rtl/bsg_permute_box_ctrl_checker.sv
// Serial bijection checker: walks the shadow one field per cycle and flags the
// first source index that appears twice. Instantiated only when
// BSG_PERMUTE_BOX_CTRL_CHECK_EN is defined.
module bsg_permute_box_ctrl_checker
    import bsg_permute_box_ctrl_pkg::*;
#(
    parameter int els_p     = 8,
    parameter int lg_els_lp = $clog2(els_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        start_i,
    input  logic                        en_i,
    input  logic [els_p*lg_els_lp-1:0]  shadow_i,
    output logic                        done_o,
    output logic                        err_o
);

    localparam int cnt_w_lp  = lg_els_lp + 1;
    localparam int seen_w_lp = 1 << lg_els_lp;

    logic [cnt_w_lp-1:0]  k_q, k_d;
    logic [seen_w_lp-1:0] seen_q, seen_d;
    logic [lg_els_lp-1:0] field_s [els_p];
    logic [lg_els_lp-1:0] sel_k_s;
    logic                 dup_s;

    for (genvar g = 0; g < els_p; g++) begin : g_field
        assign field_s[g] = shadow_i[g*lg_els_lp +: lg_els_lp];
    end

    assign sel_k_s = field_s[k_q[lg_els_lp-1:0]];
    assign dup_s   = seen_q[sel_k_s];
    assign err_o   = en_i & dup_s;
    assign done_o  = en_i & ~dup_s & (k_q == cnt_w_lp'(els_p - 1));

    // Next counter/mask: clear on start, advance one field per enabled cycle.
    always_comb begin
        k_d    = k_q;
        seen_d = seen_q;
        if (start_i) begin
            k_d    = '0;
            seen_d = '0;
        end else if (en_i) begin
            k_d             = k_q + cnt_w_lp'(1);
            seen_d[sel_k_s] = 1'b1;
        end else begin
            k_d    = k_q;
            seen_d = seen_q;
        end
    end

    // Counter and seen-mask registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            k_q    <= '0;
            seen_q <= '0;
        end else begin
            k_q    <= k_d;
            seen_q <= seen_d;
        end
    end

endmodule

// File: rtl/bsg_permute_box_ctrl.sv
// Permute-box configuration controller: host fills a shadow map, commits it,
// and the map is swapped into select_o only at a packet boundary.
// Optional feature macro: BSG_PERMUTE_BOX_CTRL_CHECK_EN -- when defined the shadow
// must be a bijection (CHECK/ERR path); otherwise any shadow, including
// broadcast maps with repeated sources, is committed directly.
module bsg_permute_box_ctrl
    import bsg_permute_box_ctrl_pkg::*;
#(
    parameter int els_p = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    bsg_permute_box_ctrl_if.slave ctrl_if
);

    localparam int lg_els_lp = $clog2(els_p);
    localparam int sel_w_lp  = els_p * lg_els_lp;
    localparam logic [sel_w_lp-1:0] ident_lp = sel_w_lp'(identity_vec(els_p, lg_els_lp));

    state_e                state_q, state_d;
    logic [sel_w_lp-1:0]   shadow_q, shadow_d;
    logic [sel_w_lp-1:0]   select_q, select_d;
    logic                  in_flight_q, in_flight_d;

    logic                  cfg_ready_s;
    logic                  commit_ready_s;
    logic                  done_s;
    logic                  err_s;
    logic                  cfg_fire_s;
    logic                  beat_s;
    logic                  swap_ok_s;

`ifdef BSG_PERMUTE_BOX_CTRL_CHECK_EN
    logic                  chk_start_s;
    logic                  chk_en_s;
    logic                  chk_done_s;
    logic                  chk_err_s;

    bsg_permute_box_ctrl_checker #(
        .els_p     (els_p),
        .lg_els_lp (lg_els_lp)
    ) u_checker (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .start_i   (chk_start_s),
        .en_i      (chk_en_s),
        .shadow_i  (shadow_q),
        .done_o    (chk_done_s),
        .err_o     (chk_err_s)
    );
`endif

    assign cfg_fire_s = ctrl_if.cfg_v_i & cfg_ready_s;
    assign beat_s     = ctrl_if.data_v_i & ctrl_if.data_ready_i;
    // Safe to swap when between packets and no new packet starts this cycle,
    // or when the closing beat of the current packet is transferring.
    assign swap_ok_s  = (~in_flight_q & ~beat_s) | (beat_s & ctrl_if.data_last_i);

    // Shadow write: one field per accepted write; indices beyond els_p match no field.
    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < els_p; i++) begin
            if (cfg_fire_s && (ctrl_if.cfg_idx_i == lg_els_lp'(i))) begin
                shadow_d[i*lg_els_lp +: lg_els_lp] = ctrl_if.cfg_sel_i;
            end else begin
                shadow_d[i*lg_els_lp +: lg_els_lp] = shadow_q[i*lg_els_lp +: lg_els_lp];
            end
        end
    end

    // Packet tracking: open on a non-last beat, close on a last beat.
    always_comb begin
        in_flight_d = in_flight_q;
        if (beat_s) begin
            in_flight_d = ~ctrl_if.data_last_i;
        end else begin
            in_flight_d = in_flight_q;
        end
    end

    // Next-state and handshake/pulse decode.
    always_comb begin
        state_d        = state_q;
        select_d       = select_q;
        cfg_ready_s    = 1'b0;
        commit_ready_s = 1'b0;
        done_s         = 1'b0;
        err_s          = 1'b0;
`ifdef BSG_PERMUTE_BOX_CTRL_CHECK_EN
        chk_start_s    = 1'b0;
        chk_en_s       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                cfg_ready_s    = 1'b1;
                commit_ready_s = 1'b1;
                if (ctrl_if.commit_v_i) begin
`ifdef BSG_PERMUTE_BOX_CTRL_CHECK_EN
                    chk_start_s = 1'b1;
                    state_d     = ST_CHECK;
`else
                    state_d     = ST_WAIT_SWAP;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
`ifdef BSG_PERMUTE_BOX_CTRL_CHECK_EN
                chk_en_s = 1'b1;
                if (chk_err_s) begin
                    state_d = ST_ERR;
                end else if (chk_done_s) begin
                    state_d = ST_WAIT_SWAP;
                end else begin
                    state_d = ST_CHECK;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_ERR: begin
`ifdef BSG_PERMUTE_BOX_CTRL_CHECK_EN
                err_s   = 1'b1;
`endif
                state_d = ST_IDLE;
            end
            ST_WAIT_SWAP: begin
                if (swap_ok_s) begin
                    done_s   = 1'b1;
                    select_d = shadow_q;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_WAIT_SWAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, shadow, active select and packet-tracking registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            shadow_q    <= ident_lp;
            select_q    <= ident_lp;
            in_flight_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            select_q    <= select_d;
            in_flight_q <= in_flight_d;
        end
    end

    assign ctrl_if.cfg_ready_o    = cfg_ready_s;
    assign ctrl_if.commit_ready_o = commit_ready_s;
    assign ctrl_if.commit_done_o  = done_s;
    assign ctrl_if.commit_err_o   = err_s;
    assign ctrl_if.busy_o         = (state_q != ST_IDLE);
    assign ctrl_if.select_o       = select_q;

endmodule
